// File: rtl/swipt_pkg.sv
// Shared types and constants for the SWIPT link generator.
// Holds the FSM encoding and the reset half-period helper.
package swipt_pkg;

  localparam int FREQ_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DIV,
    WAIT_EDGE
  } state_t;

  function automatic logic [FREQ_W-1:0] reset_hp(
    input longint unsigned clk_hz,
    input longint unsigned f_hz
  );
    return FREQ_W'(clk_hz / (2 * f_hz));
  endfunction

endpackage

// File: rtl/seq_div32.sv
// 32-cycle restoring unsigned divider, one quotient bit per cycle.
// Operands are captured on start; done pulses once quot is final.
module seq_div32
  import swipt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FREQ_W-1:0] num,
  input  logic [FREQ_W-1:0] den,
  output logic              busy,
  output logic              done,
  output logic [FREQ_W-1:0] quot
);

  logic [5:0]        r_cnt;
  logic [FREQ_W:0]   r_rem;
  logic [FREQ_W-1:0] r_q;
  logic [FREQ_W-1:0] r_den;
  logic              r_busy;
  logic              r_done;
  logic [FREQ_W:0]   w_sh;
  logic              w_ge;

  assign w_sh = {r_rem[FREQ_W-1:0], r_q[FREQ_W-1]};
  assign w_ge = (w_sh >= {1'b0, r_den});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_den  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (start) begin
      r_cnt  <= 6'd32;
      r_rem  <= '0;
      r_q    <= num;
      r_den  <= den;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_rem <= w_ge ? (w_sh - {1'b0, r_den}) : w_sh;
      r_q   <= {r_q[FREQ_W-2:0], w_ge};
      r_cnt <= r_cnt - 6'd1;
      if (r_cnt == 6'd1) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign quot = r_q;

endmodule

// File: rtl/swipt_link_gen.sv
// SWIPT transmit carrier: square-wave link at a commanded frequency,
// retimed phase-continuously on the next rising edge of link.
module swipt_link_gen
  import swipt_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned F_DEFAULT      = 40_000,
  parameter int unsigned F_MIN          = 1_000,
  parameter int unsigned F_MAX          = 200_000,
  parameter int unsigned SETTLE_PERIODS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [FREQ_W-1:0] f_cmd,
  input  logic              f_valid,
  output logic              f_ready,
  output logic              f_err,
  output logic [FREQ_W-1:0] f_cur,
  output logic              link,
  output logic              swipt_alive,
  output logic              freq_rdy
);

  localparam logic [FREQ_W-1:0] HP_RST = reset_hp(CLK_HZ, F_DEFAULT);
  localparam logic [7:0]        SETTLE = 8'(SETTLE_PERIODS);

  state_t            r_state, w_state;
  logic              r_from_run, w_from_run;
  logic              r_link, w_link;
  logic              r_alive, w_alive;
  logic              r_rdy, w_rdy;
  logic              r_err, w_err;
  logic [FREQ_W-1:0] r_f_cur, w_f_cur;
  logic [FREQ_W-1:0] r_f_new, w_f_new;
  logic [FREQ_W-1:0] r_hp, w_hp;
  logic [FREQ_W-1:0] r_hp_new, w_hp_new;
  logic [FREQ_W-1:0] r_cnt, w_cnt;
  logic [7:0]        r_settle, w_settle;

  logic              w_accept, w_in_range, w_running, w_stop;
  logic              w_tick, w_rise, w_start, w_apply;
  logic              w_div_rst, w_div_busy, w_div_done;
  logic [FREQ_W-1:0] w_quot, w_apply_hp;

  assign f_ready    = ((r_state == IDLE) || (r_state == RUN)) && !w_div_busy;
  assign w_accept   = f_valid && f_ready;
  assign w_in_range = (f_cmd >= FREQ_W'(F_MIN)) && (f_cmd <= FREQ_W'(F_MAX));
  assign w_running  = (r_state == RUN) ||
                      (((r_state == DIV) || (r_state == WAIT_EDGE)) && r_from_run);
  assign w_stop     = w_running && !en;
  assign w_tick     = (r_cnt == '0);
  assign w_rise     = w_running && w_tick && !r_link;
  assign w_start    = w_accept && w_in_range && !w_stop;
  assign w_div_rst  = rst || w_stop;
  // A finished division that lands exactly on a rising edge applies at once
  assign w_apply    = w_rise && ((r_state == WAIT_EDGE) ||
                      ((r_state == DIV) && r_from_run && w_div_done));
  assign w_apply_hp = (r_state == WAIT_EDGE) ? r_hp_new : w_quot;

  seq_div32 u_div (
    .clk   (clk),
    .rst   (w_div_rst),
    .start (w_start),
    .num   (FREQ_W'(CLK_HZ)),
    .den   ({f_cmd[FREQ_W-2:0], 1'b0}),
    .busy  (w_div_busy),
    .done  (w_div_done),
    .quot  (w_quot)
  );

  always_comb begin
    w_state    = r_state;
    w_from_run = r_from_run;
    w_link     = r_link;
    w_alive    = r_alive;
    w_rdy      = r_rdy;
    w_err      = 1'b0;
    w_f_cur    = r_f_cur;
    w_f_new    = r_f_new;
    w_hp       = r_hp;
    w_hp_new   = r_hp_new;
    w_cnt      = r_cnt;
    w_settle   = r_settle;

    if (w_running) begin
      if (w_tick) begin
        w_link = !r_link;
        w_cnt  = r_hp - 1'b1;
      end else begin
        w_cnt = r_cnt - 1'b1;
      end
    end

    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state    = DIV;
          w_from_run = 1'b0;
          w_f_new    = f_cmd;
        end else if (en) begin
          w_state  = RUN;
          w_link   = 1'b1;
          w_alive  = 1'b1;
          w_cnt    = r_hp - 1'b1;
          w_settle = 8'd1;
          w_rdy    = (SETTLE <= 8'd1);
        end
      end
      RUN: begin
        if (w_rise && (r_settle < SETTLE)) w_settle = r_settle + 8'd1;
        w_rdy = (w_settle >= SETTLE);
        if (w_start) begin
          w_state    = DIV;
          w_from_run = 1'b1;
          w_f_new    = f_cmd;
          w_rdy      = 1'b0;
        end
      end
      DIV: begin
        if (w_div_done) begin
          if (!r_from_run) begin
            w_state  = IDLE;
            w_hp     = w_quot;
            w_f_cur  = r_f_new;
            w_settle = '0;
          end else if (!w_rise) begin
            w_state  = WAIT_EDGE;
            w_hp_new = w_quot;
          end
        end
      end
      WAIT_EDGE: ;
    endcase

    if (w_apply) begin
      w_state  = RUN;
      w_hp     = w_apply_hp;
      w_cnt    = w_apply_hp - 1'b1;
      w_f_cur  = r_f_new;
      w_settle = 8'd1;
      w_rdy    = (SETTLE <= 8'd1);
    end

    if (w_accept && !w_in_range && !w_stop) w_err = 1'b1;

    if (w_stop) begin
      w_state  = IDLE;
      w_link   = 1'b0;
      w_alive  = 1'b0;
      w_rdy    = 1'b0;
      w_settle = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_from_run <= 1'b0;
      r_link     <= 1'b0;
      r_alive    <= 1'b0;
      r_rdy      <= 1'b0;
      r_err      <= 1'b0;
      r_f_cur    <= FREQ_W'(F_DEFAULT);
      r_f_new    <= FREQ_W'(F_DEFAULT);
      r_hp       <= HP_RST;
      r_hp_new   <= HP_RST;
      r_cnt      <= '0;
      r_settle   <= '0;
    end else begin
      r_state    <= w_state;
      r_from_run <= w_from_run;
      r_link     <= w_link;
      r_alive    <= w_alive;
      r_rdy      <= w_rdy;
      r_err      <= w_err;
      r_f_cur    <= w_f_cur;
      r_f_new    <= w_f_new;
      r_hp       <= w_hp;
      r_hp_new   <= w_hp_new;
      r_cnt      <= w_cnt;
      r_settle   <= w_settle;
    end
  end

  assign f_err       = r_err;
  assign f_cur       = r_f_cur;
  assign link        = r_link;
  assign swipt_alive = r_alive;
  assign freq_rdy    = r_rdy;

endmodule

// File: tb/tb_swipt_link_gen.sv
// Bench for swipt_link_gen: expected link level lengths are queued
// as stimulus is applied and checked as each level completes.
module tb_swipt_link_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] f_cmd;
  logic        f_valid;
  logic        f_ready;
  logic        f_err;
  logic [31:0] f_cur;
  logic        link;
  logic        swipt_alive;
  logic        freq_rdy;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  logic m_prev_link  = 1'b0;
  logic m_prev_alive = 1'b0;
  int   m_len        = 0;
  int   m_exp;

  always #5 clk = ~clk;

  swipt_link_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .f_cmd       (f_cmd),
    .f_valid     (f_valid),
    .f_ready     (f_ready),
    .f_err       (f_err),
    .f_cur       (f_cur),
    .link        (link),
    .swipt_alive (swipt_alive),
    .freq_rdy    (freq_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Level monitor: a level counts only if the carrier was alive at both ends.
  // Expected 0 means a transitional level bounded by the old and new timing.
  always @(negedge clk) begin
    if (link !== m_prev_link) begin
      if (m_prev_alive && swipt_alive && exp_q.size() > 0) begin
        m_exp = exp_q.pop_front();
        if (m_exp == 0)
          chk("lvl_bound", 32'((m_len >= 1000) && (m_len <= 1250)), 1);
        else
          chk("lvl_len", m_len, m_exp);
      end
      m_len <= 1;
    end else begin
      m_len <= m_len + 1;
    end
    m_prev_link  <= link;
    m_prev_alive <= swipt_alive;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise();
    logic p;
    int   n;
    n = 0;
    do begin
      p = link;
      @(negedge clk);
      n++;
    end while (!(link && !p) && n < 5000);
    chk("rise_seen", 32'(n < 5000), 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send(input logic [31:0] cmd);
    f_cmd   = cmd;
    f_valid = 1'b1;
    @(negedge clk);
    f_valid = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    f_valid = 1'b0;
    f_cmd   = '0;
    step(3);
    chk("rst_link", link, 0);
    chk("rst_alive", swipt_alive, 0);
    chk("rst_rdy", freq_rdy, 0);
    chk("rst_err", f_err, 0);
    chk("rst_fcur", f_cur, 40000);
    rst = 1'b0;
    step(1);
    chk("rst_ready", f_ready, 1);

    en = 1'b1;
    step(1);
    chk("run_link", link, 1);
    chk("run_alive", swipt_alive, 1);
    chk("run_rdy0", freq_rdy, 0);
    repeat (4) exp_q.push_back(1250);
    wait_rise();
    chk("rdy_rise2", freq_rdy, 1);
    wait_drain();

    send(500);
    chk("err_lo", f_err, 1);
    chk("err_lo_fcur", f_cur, 40000);
    step(1);
    chk("err_lo_pulse", f_err, 0);
    chk("err_lo_rdy", freq_rdy, 1);
    chk("err_lo_ready", f_ready, 1);
    send(250000);
    chk("err_hi", f_err, 1);
    chk("err_hi_fcur", f_cur, 40000);
    step(1);
    chk("err_hi_pulse", f_err, 0);
    chk("err_hi_rdy", freq_rdy, 1);

    wait_rise();
    send(50000);
    chk("chg_rdy0", freq_rdy, 0);
    chk("chg_ready0", f_ready, 0);
    chk("chg_err", f_err, 0);
    chk("chg_fcur_old", f_cur, 40000);
    exp_q.push_back(0);
    exp_q.push_back(0);
    repeat (4) exp_q.push_back(1000);
    wait_drain();
    chk("chg_fcur", f_cur, 50000);
    chk("chg_rdy1", freq_rdy, 1);

    step(300);
    rst = 1'b1;
    en  = 1'b0;
    step(1);
    chk("mrst_link", link, 0);
    chk("mrst_alive", swipt_alive, 0);
    chk("mrst_rdy", freq_rdy, 0);
    chk("mrst_fcur", f_cur, 40000);
    rst = 1'b0;
    en  = 1'b1;
    step(1);
    repeat (2) exp_q.push_back(1250);
    wait_drain();
    en = 1'b0;
    step(1);
    chk("stop_alive", swipt_alive, 0);

    send(200000);
    chk("max_err", f_err, 0);
    chk("max_busy", f_ready, 0);
    step(32);
    chk("max_busy32", f_ready, 0);
    chk("max_fcur_old", f_cur, 40000);
    step(1);
    chk("max_done", f_ready, 1);
    chk("max_fcur", f_cur, 200000);

    send(25000);
    step(34);
    chk("idle_fcur", f_cur, 25000);
    chk("idle_link", link, 0);
    en = 1'b1;
    step(1);
    repeat (2) exp_q.push_back(2000);
    wait_drain();
    chk("slow_fcur", f_cur, 25000);

    wait_rise();
    send(50000);
    step(9);
    en = 1'b0;
    step(1);
    chk("abort_link", link, 0);
    chk("abort_alive", swipt_alive, 0);
    chk("abort_rdy", freq_rdy, 0);
    chk("abort_fcur", f_cur, 25000);
    step(40);
    chk("abort_fcur_late", f_cur, 25000);
    chk("abort_ready", f_ready, 1);
    en = 1'b1;
    step(1);
    repeat (2) exp_q.push_back(2000);
    wait_drain();
    chk("resume_fcur", f_cur, 25000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/swipt_link_gen.md
# swipt_link_gen

- Transmit end of the SWIPT link: generates the square-wave `link` carrier that the receiver-side PLL locks to.
- Also drives the `swipt_alive` and `freq_rdy` qualifiers that the PLL consumes.
- Output frequency is commanded in Hz through a valid/ready port. Each command is converted to a half-period count by a sequential divider.
- A new frequency is applied phase-continuously at the next rising edge of `link`.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency in Hz.
- `F_DEFAULT`, 40_000: frequency loaded at reset (32'h9C40).
- `F_MIN`, 1_000: lowest legal command in Hz. Must be > 0.
- `F_MAX`, 200_000: highest legal command in Hz.
- `SETTLE_PERIODS`, 2: number of full `link` periods at the new frequency before `freq_rdy` rises.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable. High means `link` toggles; low means idle.
- `f_cmd` in 32: commanded frequency in Hz.
- `f_valid` in 1: `f_cmd` is valid.
- `f_ready` out 1: the block can accept a command.
- `f_err` out 1: one-cycle pulse when a command is rejected as out of range.
- `f_cur` out 32: frequency currently in effect, in Hz.
- `link` out 1: carrier output.
- `swipt_alive` out 1: high while the carrier is running.
- `freq_rdy` out 1: high when the carrier has settled at `f_cur`.

## Operation
- States: IDLE, RUN, DIV, WAIT_EDGE. A flag records whether DIV was entered from IDLE or from RUN.
- Values after reset: state IDLE, `link`=0, `swipt_alive`=0, `freq_rdy`=0, `f_err`=0, `f_cur`=F_DEFAULT.
- Half-period register `hp` resets to CLK_HZ/(2·F_DEFAULT), an elaboration-time constant.
- `f_ready` = 1 in IDLE and RUN, 0 in DIV and WAIT_EDGE.
- A command is accepted when `f_valid` and `f_ready` are both high.
- Out-of-range command (`f_cmd` < F_MIN or `f_cmd` > F_MAX):
  - The command is still accepted.
  - `f_err`=1 on the next cycle.
  - State, `hp`, `f_cur` and `freq_rdy` do not change.
- In-range command: latch `f_cmd`, go to DIV, start the divider computing CLK_HZ/(2·f_cmd).
  - Quotient is truncated; width is 32 bits.
- IDLE → RUN: when `en`=1, the next cycle has `link`=1 and `swipt_alive`=1, and the counter `cnt` loads `hp`−1.
- RUN:
  - Each cycle, if `cnt`≠0 then `cnt` decrements.
  - If `cnt`=0, `link` toggles and `cnt` reloads `hp`−1.
  - Result: each `link` level lasts exactly `hp` cycles.
- Settle counter: counts rising edges of `link` since the last frequency change, saturating at SETTLE_PERIODS.
  - `freq_rdy` goes high on the cycle the count reaches SETTLE_PERIODS.
- DIV:
  - `link` keeps toggling at the old `hp`.
  - `freq_rdy` goes low on the cycle after acceptance.
  - When the divider finishes:
    - If DIV was entered from IDLE: load `hp`, update `f_cur`, return to IDLE.
    - If DIV was entered from RUN: go to WAIT_EDGE.
- WAIT_EDGE:
  - The old timing continues until `cnt`=0 with `link`=0.
  - On that cycle: `link` rises, `cnt` loads new `hp`−1, `f_cur` updates, settle counter clears to 1, state returns to RUN.
- `en` falls in RUN, DIV or WAIT_EDGE:
  - On the next cycle: state IDLE, `link`=0, `swipt_alive`=0, `freq_rdy`=0.
  - Any pending division is discarded, and `hp` and `f_cur` keep their previous values.
- `rst` in any state, including mid-division, restores all reset values on the next cycle.
- Acceptance and `en` falling in the same cycle: `en` wins and the command is discarded.

## Timing
- Divider latency: 32 cycles after the acceptance cycle. The result is valid in cycle 33.
- Frequency change: new `hp` takes effect at the first rising edge of `link` after division completes. There is no glitch and no partial period.
- `freq_rdy`:
  - Low from acceptance+1 until SETTLE_PERIODS rising edges of `link` have occurred at the new `hp`.
  - The edge that applies the new `hp` counts as the first of these.
- `link` period = 2·`hp` cycles. The frequency error comes only from truncation.

## Structure
- Package `swipt_pkg` holds:
  - state enum;
  - `FREQ_W`=32;
  - function computing the reset `hp` from CLK_HZ and F_DEFAULT.
- Sub-module `seq_div32`:
  - 32-cycle restoring unsigned divider, one quotient bit per cycle;
  - ports `start`/`busy`/`done`, `num`, `den`, `quot`;
  - synchronous active-high `rst`.

## Test plan
- Reset, then `en`=1 with defaults:
  - `link` high 1250 cycles, low 1250 cycles;
  - `swipt_alive`=1 from the first high cycle;
  - `freq_rdy` rises at the 2nd rising edge.
- In RUN, `f_cmd`=50_000 accepted:
  - `freq_rdy` low on the next cycle;
  - no `link` level shorter than 1000 cycles or longer than 1250 cycles;
  - after the first new rising edge, levels are 1000 cycles and `f_cur`=50_000.
- `f_cmd`=500 and `f_cmd`=250_000: `f_err` pulses 1 cycle each; `f_cur` stays 40_000 and `freq_rdy` stays high.
- In IDLE, `f_cmd`=25_000, then `en`=1: first level lasts 2000 cycles and `f_cur`=25_000.
- `en` dropped 10 cycles into DIV: `link`=0 and `swipt_alive`=0 on the next cycle; `f_cur` unchanged; re-enabling resumes at the old `hp`.
- `rst` asserted mid-RUN at 50 kHz: outputs return to reset values and `f_cur`=40_000; the next `en` produces 1250-cycle levels.
